// File: rtl/mem_resp.sv
// Single-port word memory behind a valid/ready request/response pair, with a fixed response delay.
// Define MEM_RESP_ERR_EN to flag misaligned or out-of-window accesses instead of wrapping them.
module mem_resp #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_LOG2  = 8,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Write,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_WData,
  input  logic [3:0]  Req_Be,
  output logic        Rsp_Valid,
  input  logic        Rsp_Ready,
  output logic [31:0] Rsp_RData,
  output logic        Rsp_Err,
  output logic [1:0]  dbgState
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid, once raised, holds its payload stable until that edge.

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, stateNext;
  logic [3:0]  cnt, cntNext;
  logic        enterResp;
  logic        accept;

  logic        capWrite;
  logic [31:0] capAddr;
  logic [31:0] capWData;
  logic [3:0]  capBe;

  logic        txWrite;
  logic [31:0] txAddr;
  logic [31:0] txWData;
  logic [3:0]  txBe;
  logic [31:0] txOffset;
  logic [DEPTH_LOG2-1:0] txIdx;
  logic        txErr;
  logic        unusedOffsetBits;

  logic [31:0] mem [DEPTH];

  assign Req_Ready = rstb && (state == IDLE);
  assign accept    = Req_Valid && Req_Ready;
  assign dbgState  = state;

  // With no wait states the response is built in the acceptance edge, so the live
  // request is used in IDLE; otherwise the captured copy is.
  always_comb begin
    txWrite = capWrite;
    txAddr  = capAddr;
    txWData = capWData;
    txBe    = capBe;
    if (state == IDLE) begin
      txWrite = Req_Write;
      txAddr  = Req_Addr;
      txWData = Req_WData;
      txBe    = Req_Be;
    end
  end

  assign txOffset = txAddr - ADDR_BASE;
  assign txIdx    = txOffset[DEPTH_LOG2+1:2];
  assign unusedOffsetBits = ^{txOffset[31:DEPTH_LOG2+2], txOffset[1:0]};

`ifdef MEM_RESP_ERR_EN
  localparam logic [32:0] WINDOW_END = {1'b0, ADDR_BASE} + (33'd4 << DEPTH_LOG2);

  always_comb begin
    txErr = 1'b0;
    if ((txAddr[1:0] != 2'b00) ||
        ({1'b0, txAddr} < {1'b0, ADDR_BASE}) ||
        ({1'b0, txAddr} >= WINDOW_END)) begin
      txErr = 1'b1;
    end
  end
`else
  assign txErr = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    enterResp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            stateNext = RESP;
            enterResp = 1'b1;
          end else begin
            stateNext = WAIT;
            cntNext   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          stateNext = RESP;
          enterResp = 1'b1;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      RESP: begin
        if (Rsp_Ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      Rsp_Valid <= 1'b0;
      Rsp_RData <= 32'd0;
      Rsp_Err   <= 1'b0;
      capWrite  <= 1'b0;
      capAddr   <= 32'd0;
      capWData  <= 32'd0;
      capBe     <= 4'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (accept) begin
        capWrite <= Req_Write;
        capAddr  <= Req_Addr;
        capWData <= Req_WData;
        capBe    <= Req_Be;
      end
      if (enterResp) begin
        Rsp_Valid <= 1'b1;
        Rsp_Err   <= txErr;
        Rsp_RData <= (!txWrite && !txErr) ? mem[txIdx] : 32'd0;
      end else if ((state == RESP) && Rsp_Ready) begin
        Rsp_Valid <= 1'b0;
      end
    end
  end

  // Storage is never reset; a store abandoned by reset must not land.
  always_ff @(posedge clk) begin
    if (rstb && enterResp && txWrite && !txErr) begin
      for (int b = 0; b < 4; b++) begin
        if (txBe[b]) begin
          mem[txIdx][8*b +: 8] <= txWData[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_resp.sv
// Randomized bench for mem_resp against a word-array reference model.
module tb_mem_resp;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int DL    = 8;
  localparam int WC    = 1;
  localparam int DEPTH = 1 << DL;
`ifdef MEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        Req_Valid = 1'b0;
  logic        Req_Ready;
  logic        Req_Write = 1'b0;
  logic [31:0] Req_Addr = 32'd0;
  logic [31:0] Req_WData = 32'd0;
  logic [3:0]  Req_Be = 4'd0;
  logic        Rsp_Valid;
  logic        Rsp_Ready = 1'b0;
  logic [31:0] Rsp_RData;
  logic        Rsp_Err;
  logic [1:0]  dbgState;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastAcc = 0;
  logic [31:0] model_mem [DEPTH];
  logic [32:0] exp_q[$];

  mem_resp #(
    .ADDR_BASE(BASE),
    .DEPTH_LOG2(DL),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .Req_Valid(Req_Valid),
    .Req_Ready(Req_Ready),
    .Req_Write(Req_Write),
    .Req_Addr(Req_Addr),
    .Req_WData(Req_WData),
    .Req_Be(Req_Be),
    .Rsp_Valid(Rsp_Valid),
    .Rsp_Ready(Rsp_Ready),
    .Rsp_RData(Rsp_RData),
    .Rsp_Err(Rsp_Err),
    .dbgState(dbgState)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: returns {err, rdata} and applies the store to the word array.
  function automatic logic [32:0] model_access(input logic w, input logic [31:0] a,
                                               input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] off;
    int idx;
    logic err;
    off = a - BASE;
    err = ERR_EN && ((a % 4) != 0 || off >= 32'(4 * DEPTH));
    idx = int'((off / 4) % DEPTH);
    if (err) return {1'b1, 32'd0};
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
      return {1'b0, 32'd0};
    end
    return {1'b0, model_mem[idx]};
  endfunction

  // Called at a negedge; returns at the negedge after the response is consumed.
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input int hold, input string name);
    int n;
    int lat;
    bit busyBad;
    logic [32:0] exp;
    logic [31:0] d0;
    logic e0;
    Req_Valid = 1'b1; Req_Write = w; Req_Addr = a; Req_WData = wd; Req_Be = be;
    n = 0;
    while (Req_Ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (Req_Ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: Req_Ready=%b required 1", name, Req_Ready);
      Req_Valid = 1'b0;
      return;
    end
    lastAcc = cyc + 1;
    exp_q.push_back(model_access(w, a, wd, be));
    @(negedge clk);
    Req_Valid = 1'b0; Req_Write = 1'($urandom); Req_Addr = $urandom;
    Req_WData = $urandom; Req_Be = 4'($urandom);
    lat = 1; busyBad = 1'b0;
    while (Rsp_Valid !== 1'b1 && lat < 40) begin
      if (Req_Ready !== 1'b0) busyBad = 1'b1;
      @(negedge clk); lat++;
    end
    exp = exp_q.pop_front();
    checks++;
    if (lat != WC + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, WC + 1);
    end
    checks++;
    if (busyBad) begin
      errors++;
      $display("FAIL %s busy_ready: Req_Ready high while waiting, required 0", name);
    end
    if (Rsp_Valid !== 1'b1) return;
    d0 = Rsp_RData; e0 = Rsp_Err;
    checks++;
    if (Rsp_RData !== exp[31:0]) begin
      errors++;
      $display("FAIL %s rdata: got %h required %h", name, Rsp_RData, exp[31:0]);
    end
    checks++;
    if (Rsp_Err !== exp[32]) begin
      errors++;
      $display("FAIL %s err: got %b required %b", name, Rsp_Err, exp[32]);
    end
    for (int i = 0; i < hold; i++) begin
      Req_Addr = $urandom; Req_WData = $urandom;
      @(negedge clk);
      checks++;
      if (Rsp_Valid !== 1'b1 || Rsp_RData !== d0 || Rsp_Err !== e0 || Req_Ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold: valid=%b rdata=%h err=%b ready=%b required 1 %h %b 0",
                 name, Rsp_Valid, Rsp_RData, Rsp_Err, Req_Ready, d0, e0);
      end
    end
    Rsp_Ready = 1'b1;
    checks++;
    if (Req_Ready !== 1'b0) begin
      errors++;
      $display("FAIL %s consume_ready: Req_Ready=%b required 0", name, Req_Ready);
    end
    @(negedge clk);
    Rsp_Ready = 1'b0;
    checks++;
    if (Rsp_Valid !== 1'b0 || Req_Ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: valid=%b ready=%b required 0 1", name, Rsp_Valid, Req_Ready);
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (Req_Ready !== 1'b0 || Rsp_Valid !== 1'b0 || Rsp_RData !== 32'd0 || Rsp_Err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b required 0 0 0 0",
               Req_Ready, Rsp_Valid, Rsp_RData, Rsp_Err);
    end
    rstb = 1'b1;
    @(negedge clk);
    checks++;
    if (Req_Ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: Req_Ready=%b required 1", Req_Ready);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++)
      do_txn(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 0, "fill");
  endtask

  task automatic test_basic();
    do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, "basic_store");
    do_txn(1'b0, 32'h10, 32'd0, 4'h0, 0, "basic_load");
  endtask

  task automatic test_byte_enable();
    do_txn(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 0, "be_fill");
    do_txn(1'b1, 32'h20, 32'h1122_3344, 4'b0101, 0, "be_store");
    do_txn(1'b0, 32'h20, 32'd0, 4'h0, 0, "be_load");
    do_txn(1'b1, 32'h20, 32'h5555_AAAA, 4'b0000, 0, "be_none");
    do_txn(1'b0, 32'h20, 32'd0, 4'h0, 0, "be_none_load");
  endtask

  task automatic test_backpressure();
    do_txn(1'b0, 32'h10, 32'd0, 4'h0, 5, "backpressure");
  endtask

  task automatic test_back_to_back();
    int prev;
    for (int k = 0; k < 4; k++) begin
      prev = lastAcc;
      do_txn(1'($urandom), BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), $urandom,
             4'($urandom), 0, "b2b");
      if (k > 0) begin
        checks++;
        if (lastAcc - prev != WC + 2) begin
          errors++;
          $display("FAIL b2b spacing: got %0d required %0d", lastAcc - prev, WC + 2);
        end
      end
    end
  endtask

  task automatic test_range();
    do_txn(1'b0, 32'h402, 32'd0, 4'h0, 0, "range_load_misaligned");
    do_txn(1'b1, 32'h400, 32'hCAFE_F00D, 4'hF, 0, "range_store_oob");
    do_txn(1'b0, 32'h0, 32'd0, 4'h0, 0, "range_word0");
  endtask

  task automatic test_reset_in_wait();
    Req_Valid = 1'b1; Req_Write = 1'b1; Req_Addr = 32'h30;
    Req_WData = 32'h0BAD_0BAD; Req_Be = 4'hF;
    checks++;
    if (Req_Ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait accept: Req_Ready=%b required 1", Req_Ready);
    end
    @(negedge clk);
    Req_Valid = 1'b0;
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    checks++;
    if (Rsp_Valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait valid: Rsp_Valid=%b required 0", Rsp_Valid);
    end
    @(negedge clk);
    checks++;
    if (Rsp_Valid !== 1'b0 || Req_Ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait release: valid=%b ready=%b required 0 1", Rsp_Valid, Req_Ready);
    end
    do_txn(1'b0, 32'h30, 32'd0, 4'h0, 0, "rst_wait_load");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
        1: a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 4 * DEPTH - 1));
        default: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      endcase
      do_txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_byte_enable();
    test_backpressure();
    test_back_to_back();
    test_range();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
